// File: rtl/dvfs_pkg.sv
// -----------------------------------------------------------------------------
// dvfs_pkg
// Shared definitions for the DVFS divided-clock consumer logic: level codes,
// divider bus width, switch FSM state encoding, and the helper that maps a
// level and a set of rising-edge strobes to a clock-enable value.
// -----------------------------------------------------------------------------
package dvfs_pkg;

  // Divider bus is {clk_div8, clk_div4, clk_div2}
  localparam int DIV_W = 3;

  localparam logic [1:0] LVL_FULL = 2'd0;
  localparam logic [1:0] LVL_DIV2 = 2'd1;
  localparam logic [1:0] LVL_DIV4 = 2'd2;
  localparam logic [1:0] LVL_DIV8 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BND = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  // Level 0 runs at full rate; every other level follows the rising edge
  // of the matching divider bit.
  function automatic logic sel_enable(input logic [1:0]       level,
                                      input logic [DIV_W-1:0] rise);
    logic en;
    en = 1'b0;
    case (level)
      LVL_FULL: en = 1'b1;
      LVL_DIV2: en = rise[0];
      LVL_DIV4: en = rise[1];
      LVL_DIV8: en = rise[2];
      default:  en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/dvfs_edge_detect.sv
// -----------------------------------------------------------------------------
// dvfs_edge_detect
// Registers the divided-clock bus and reports rising edges per bit plus the
// common frame boundary (all dividers high -> all dividers low). The boundary
// cycle carries no rising edge on any bit, which is what makes it a safe
// point to change rate.
//
// Ports
//   clk_in      in   system clock
//   rst         in   asynchronous, active-high reset
//   i_div       in   {clk_div8, clk_div4, clk_div2} sampled in clk_in domain
//   o_rise      out  per-bit rising-edge strobe (combinational)
//   o_boundary  out  frame boundary strobe, prev==111 and now==000
// -----------------------------------------------------------------------------
module dvfs_edge_detect
  import dvfs_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst,
  input  logic [DIV_W-1:0] i_div,
  output logic [DIV_W-1:0] o_rise,
  output logic             o_boundary
);

  logic [DIV_W-1:0] r_prev;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
    end else begin
      r_prev <= i_div;
    end
  end

  assign o_rise     = i_div & ~r_prev;
  assign o_boundary = (r_prev == {DIV_W{1'b1}}) && (i_div == {DIV_W{1'b0}});

endmodule

// File: rtl/dvfs_freq_switch.sv
// -----------------------------------------------------------------------------
// dvfs_freq_switch
// Consumer side of the DVFS divided-clock bus. Turns the sampled divider bus
// into a clean clock-enable stream at the selected level and changes level
// only on the common divider frame boundary, so no runt or doubled enable
// pulses appear across a switch. Level changes arrive on a valid/ready
// handshake from the DVFS policy controller.
//
// Ports
//   clk_in       in   system clock
//   rst          in   asynchronous, active-high reset
//   i_div_in     in   {clk_div8, clk_div4, clk_div2}
//   i_req_valid  in   level-change request valid
//   i_req_level  in   requested level (0=full, 1=/2, 2=/4, 3=/8)
//   o_req_ready  out  request can be accepted (IDLE)
//   o_cur_level  out  level currently driving o_clk_en
//   o_clk_en     out  registered enable, one pulse per selected rising edge
//   o_busy       out  switch in progress
//   o_done       out  one-cycle pulse, request completed
//   o_err        out  one-cycle pulse, request aborted on timeout
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | ready for a request; clk_en follows cur_level
// ST_WAIT_BND | target latched, waiting for the 111->000 frame boundary
// ST_DONE     | done pulse cycle, back to IDLE next
// -----------------------------------------------------------------------------
module dvfs_freq_switch
  import dvfs_pkg::*;
#(
  parameter logic [1:0] RESET_LEVEL = 2'd0,
  parameter int         TIMEOUT     = 64
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [DIV_W-1:0] i_div_in,
  input  logic             i_req_valid,
  input  logic [1:0]       i_req_level,
  output logic             o_req_ready,
  output logic [1:0]       o_cur_level,
  output logic             o_clk_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam int                TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

  logic [DIV_W-1:0] w_rise;
  logic             w_boundary;

  state_t           r_state;
  logic [1:0]       r_cur_level;
  logic [1:0]       r_tgt;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_clk_en;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  dvfs_edge_detect u_edge (
    .clk_in     (clk_in),
    .rst        (rst),
    .i_div      (i_div_in),
    .o_rise     (w_rise),
    .o_boundary (w_boundary)
  );

  // Ready, busy and done are registered as functions of the state being
  // entered, so they line up with r_state: ready==IDLE (except the first
  // cycle out of reset), busy==WAIT_BND|DONE, done==DONE.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cur_level <= RESET_LEVEL;
      r_tgt       <= RESET_LEVEL;
      r_to_cnt    <= '0;
      r_clk_en    <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      // Selection uses the level in force during the detecting cycle; a
      // level applied at the boundary takes effect from the next cycle.
      r_clk_en <= sel_enable(r_cur_level, w_rise);

      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (r_ready && i_req_valid) begin
            r_tgt    <= i_req_level;
            r_to_cnt <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            if (i_req_level == r_cur_level) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_WAIT_BND;
            end
          end
        end

        ST_WAIT_BND: begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
          // Boundary is checked first so a boundary on the last allowed
          // cycle still completes the switch.
          if (w_boundary) begin
            r_cur_level <= r_tgt;
            r_state     <= ST_DONE;
            r_done      <= 1'b1;
          end else if (r_to_cnt == TO_LAST) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready = r_ready;
  assign o_cur_level = r_cur_level;
  assign o_clk_en    = r_clk_en;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_dvfs_freq_switch.sv
module tb_dvfs_freq_switch;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       div_rst = 1'b1;
  logic [2:0] div_cnt;
  logic       i_req_valid = 1'b0;
  logic [1:0] i_req_level = 2'd0;
  logic       o_req_ready;
  logic [1:0] o_cur_level;
  logic       o_clk_en;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_pulse = 0;
  bit have_last = 1'b0;
  int gaps[$];
  int cyc_done = 0;

  always #5 clk_in = ~clk_in;

  // 3-bit divider: bit0 = clk_div2, bit1 = clk_div4, bit2 = clk_div8
  always_ff @(posedge clk_in or posedge div_rst) begin
    if (div_rst) div_cnt <= 3'd0;
    else         div_cnt <= div_cnt + 3'd1;
  end

  dvfs_freq_switch #(.RESET_LEVEL(2'd0), .TIMEOUT(64)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .i_div_in    (div_cnt),
    .i_req_valid (i_req_valid),
    .i_req_level (i_req_level),
    .o_req_ready (o_req_ready),
    .o_cur_level (o_cur_level),
    .o_clk_en    (o_clk_en),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
    if (o_clk_en === 1'b1) begin
      if (have_last) gaps.push_back(cyc - last_pulse);
      last_pulse = cyc;
      have_last = 1'b1;
    end
  endtask

  task automatic request(input logic [1:0] lvl);
    int n;
    n = 0;
    i_req_valid = 1'b1;
    i_req_level = lvl;
    while (o_req_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("req_ready_seen", {31'd0, o_req_ready}, 32'd1);
    step();
    i_req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (o_done !== 1'b1 && o_err !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("done_within_bound", {31'd0, o_done}, 32'd1);
    cyc_done = cyc;
  endtask

  task automatic mark_done();
    gaps.delete();
    last_pulse = cyc_done;
    have_last = 1'b1;
  endtask

  // first: cycles from reference point to first pulse; period: following gaps
  task automatic check_cadence(input string tag, input int first, input int period, input int n);
    int k;
    int bad;
    k = 0;
    bad = 0;
    while (gaps.size() < n && k < 200) begin
      step();
      k++;
    end
    chk({tag, "_count"}, gaps.size(), n);
    chk({tag, "_first"}, gaps.size() > 0 ? gaps[0] : -1, first);
    for (int i = 1; i < gaps.size(); i++) if (gaps[i] != period) bad++;
    chk({tag, "_period_bad"}, bad, 0);
  endtask

  initial begin
    int mn;
    int mx;
    int bad;
    int cnt;

    // reset
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_clk_en", {31'd0, o_clk_en}, 0);
    chk("rst_ready", {31'd0, o_req_ready}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_done_err", {30'd0, o_done, o_err}, 0);
    chk("rst_level", {30'd0, o_cur_level}, 0);
    rst = 1'b0;
    div_rst = 1'b0;
    step();
    chk("post_rst_clk_en", {31'd0, o_clk_en}, 1);
    chk("post_rst_ready", {31'd0, o_req_ready}, 1);
    chk("post_rst_level", {30'd0, o_cur_level}, 0);
    gaps.delete();
    last_pulse = cyc;
    have_last = 1'b1;
    check_cadence("lvl0", 1, 1, 8);

    // 0 -> 3
    request(2'd3);
    chk("busy_03", {31'd0, o_busy}, 1);
    wait_done();
    chk("err_03", {31'd0, o_err}, 0);
    chk("level_03", {30'd0, o_cur_level}, 3);
    chk("bnd_align_03", {29'd0, div_cnt}, 1);
    mark_done();
    check_cadence("lvl3", 4, 8, 5);
    chk("idle_after_03", {30'd0, o_busy, o_req_ready}, 1);

    // 3 -> 1, no spacing below 2 or above 8 across the switch
    gaps.delete();
    request(2'd1);
    wait_done();
    mn = 99;
    mx = 0;
    foreach (gaps[i]) begin
      if (gaps[i] < mn) mn = gaps[i];
      if (gaps[i] > mx) mx = gaps[i];
    end
    chk("gap_min_31", {31'd0, mn >= 2}, 1);
    chk("gap_max_31", {31'd0, mx <= 8}, 1);
    chk("level_31", {30'd0, o_cur_level}, 1);
    chk("bnd_align_31", {29'd0, div_cnt}, 1);
    mark_done();
    check_cadence("lvl1", 1, 2, 5);

    // 1 -> 2
    request(2'd2);
    wait_done();
    chk("level_12", {30'd0, o_cur_level}, 2);
    mark_done();
    check_cadence("lvl2", 2, 4, 4);

    // 2 -> 2: done the cycle after acceptance, cadence unbroken
    gaps.delete();
    request(2'd2);
    chk("eq_done", {31'd0, o_done}, 1);
    chk("eq_busy", {31'd0, o_busy}, 1);
    chk("eq_level", {30'd0, o_cur_level}, 2);
    step();
    chk("eq_done_clear", {31'd0, o_done}, 0);
    chk("eq_ready", {31'd0, o_req_ready}, 1);
    repeat (20) step();
    bad = 0;
    foreach (gaps[i]) if (gaps[i] != 4) bad++;
    chk("eq_cadence_bad", bad, 0);
    chk("eq_cadence_count", {31'd0, gaps.size() >= 5}, 1);

    // 2 -> 0
    request(2'd0);
    wait_done();
    chk("level_20", {30'd0, o_cur_level}, 0);
    mark_done();
    check_cadence("lvl0b", 1, 1, 4);

    // divider stalled: switch 0 -> 2 times out 64 cycles after acceptance
    div_rst = 1'b1;
    step();
    step();
    request(2'd2);
    chk("to_busy", {31'd0, o_busy}, 1);
    repeat (63) step();
    chk("to_not_early", {31'd0, o_err}, 0);
    chk("to_busy_63", {31'd0, o_busy}, 1);
    step();
    chk("to_err", {31'd0, o_err}, 1);
    chk("to_level", {30'd0, o_cur_level}, 0);
    chk("to_no_done", {31'd0, o_done}, 0);
    chk("to_ready", {31'd0, o_req_ready}, 1);
    step();
    chk("to_err_clear", {31'd0, o_err}, 0);

    // boundary on the last timeout cycle: done wins
    request(2'd1);
    repeat (55) step();
    div_rst = 1'b0;
    repeat (8) step();
    chk("coinc_pre", {30'd0, o_done, o_err}, 0);
    step();
    chk("coinc_done", {31'd0, o_done}, 1);
    chk("coinc_no_err", {31'd0, o_err}, 0);
    chk("coinc_level", {30'd0, o_cur_level}, 1);

    // stalled divider at level 1: no enable pulses
    div_rst = 1'b1;
    repeat (3) step();
    cnt = 0;
    repeat (20) begin
      step();
      if (o_clk_en === 1'b1) cnt++;
    end
    chk("stall_no_pulse", cnt, 0);

    // reset during WAIT_BND
    request(2'd3);
    repeat (5) step();
    chk("mid_busy", {31'd0, o_busy}, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_level", {30'd0, o_cur_level}, 0);
    chk("mid_rst_outs", {28'd0, o_clk_en, o_req_ready, o_busy, o_done}, 0);
    chk("mid_rst_err", {31'd0, o_err}, 0);
    step();
    step();
    chk("mid_rst_hold_en", {31'd0, o_clk_en}, 0);
    rst = 1'b0;
    div_rst = 1'b0;
    step();
    chk("mid_post_en", {31'd0, o_clk_en}, 1);
    chk("mid_post_ready", {31'd0, o_req_ready}, 1);
    cnt = 0;
    repeat (80) begin
      step();
      if (o_done === 1'b1 || o_err === 1'b1) cnt++;
    end
    chk("mid_no_done_err", cnt, 0);
    chk("mid_level", {30'd0, o_cur_level}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
